watchdog_reset: RTL and testbench



---
 rtl/watchdog_reset_if.sv | 30 +++
 rtl/watchdog_reset.sv | 113 +++++++++++
 tb/tb_watchdog_reset.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/watchdog_reset_if.sv
// Control/status bundle between a watchdog client and the watchdog_reset block.
// The client drives arm/service/clear strobes and observes the reset request and status.
interface watchdog_reset_if #(
    parameter int NumCntBits = 10
);
    logic                  enable;
    logic                  kick;
    logic                  clear_expired;
    logic                  reset_req;
    logic                  expired;
    logic [NumCntBits-1:0] remaining;

    modport master (
        output enable,
        output kick,
        output clear_expired,
        input  reset_req,
        input  expired,
        input  remaining
    );

    modport slave (
        input  enable,
        input  kick,
        input  clear_expired,
        output reset_req,
        output expired,
        output remaining
    );
endinterface

// File: rtl/watchdog_reset.sv
// Watchdog timer: counts down while armed, reloads on kick, and on expiry raises a
// fixed-length registered reset request plus a sticky expired flag.
module watchdog_reset #(
    parameter int TimeoutCycles = 1000,
    parameter int PulseCycles   = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    watchdog_reset_if.slave  bus
);
    localparam int MaxCycles  = (TimeoutCycles > PulseCycles) ? TimeoutCycles : PulseCycles;
    localparam int NumCntBits = $clog2(MaxCycles + 1);

    localparam logic [NumCntBits-1:0] CntZero    = {NumCntBits{1'b0}};
    localparam logic [NumCntBits-1:0] CntOne     = NumCntBits'(1);
    localparam logic [NumCntBits-1:0] CntTimeout = NumCntBits'(TimeoutCycles);
    localparam logic [NumCntBits-1:0] CntPulse   = NumCntBits'(PulseCycles);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_FIRING  = 2'd2
    } state_e;

    state_e                state_q,     state_d;
    logic [NumCntBits-1:0] cnt_q,       cnt_d;
    logic                  expired_q,   expired_d;
    logic                  reset_req_q, reset_req_d;
    logic [NumCntBits-1:0] remaining_q, remaining_d;

    // Next-state, counter and sticky-flag logic; outputs derive from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        expired_d = expired_q;

        // A set on FIRING entry below overrides this clear.
        if (bus.clear_expired) begin
            expired_d = 1'b0;
        end else begin
            expired_d = expired_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_RUNNING;
                    cnt_d   = CntTimeout;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUNNING: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (bus.kick) begin
                    cnt_d = CntTimeout;
                end else if (cnt_q == CntOne) begin
                    state_d   = ST_FIRING;
                    cnt_d     = CntPulse;
                    expired_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            ST_FIRING: begin
                // Pulse always runs to completion; enable only picks the exit target.
                if (cnt_q == CntOne) begin
                    if (bus.enable) begin
                        state_d = ST_RUNNING;
                        cnt_d   = CntTimeout;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CntZero;
            end
        endcase

        reset_req_d = (state_d == ST_FIRING);
        if (state_d == ST_RUNNING) begin
            remaining_d = cnt_d;
        end else begin
            remaining_d = CntZero;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CntZero;
            expired_q   <= 1'b0;
            reset_req_q <= 1'b0;
            remaining_q <= CntZero;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            expired_q   <= expired_d;
            reset_req_q <= reset_req_d;
            remaining_q <= remaining_d;
        end
    end

    assign bus.reset_req = reset_req_q;
    assign bus.expired   = expired_q;
    assign bus.remaining = remaining_q;
endmodule

// File: tb/tb_watchdog_reset.sv
// Directed bench for watchdog_reset with TimeoutCycles=8, PulseCycles=3.
module tb_watchdog_reset;
    localparam int TimeoutCycles = 8;
    localparam int PulseCycles   = 3;
    localparam int NumCntBits    = 4;

    logic sys_clk;
    logic reset;
    int   checks;
    int   errors;

    watchdog_reset_if #(.NumCntBits(NumCntBits)) bus ();

    watchdog_reset #(
        .TimeoutCycles(TimeoutCycles),
        .PulseCycles  (PulseCycles)
    ) dut (
        .sys_clk(sys_clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic req, input logic exp_flag, input int rem);
        chk({tag, "_req"}, {31'd0, bus.reset_req}, {31'd0, req});
        chk({tag, "_exp"}, {31'd0, bus.expired},   {31'd0, exp_flag});
        chk({tag, "_rem"}, {28'd0, bus.remaining}, rem);
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b1;
        bus.enable        = 1'b0;
        bus.kick          = 1'b0;
        bus.clear_expired = 1'b0;
        @(negedge sys_clk);
        tick(2);
        reset = 1'b0;
        chk_out("reset", 1'b0, 1'b0, 0);

        for (int i = 0; i < 10; i++) begin
            tick();
            chk_out("idle", 1'b0, 1'b0, 0);
        end

        // No kicks: count 8..1, 3-cycle pulse, then reload.
        bus.enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk_out("count", 1'b0, 1'b0, 9 - i);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("fire", 1'b1, 1'b1, 0);
        end
        tick();
        chk_out("reload", 1'b0, 1'b1, 8);

        // Periodic kicks never let it fire.
        for (int i = 0; i < 100; i++) begin
            bus.kick = (i % 5 == 0) ? 1'b1 : 1'b0;
            tick();
            chk("kick_noreq", {31'd0, bus.reset_req}, 32'd0);
        end
        bus.kick = 1'b1;
        tick();
        bus.kick = 1'b0;
        chk_out("kick_load", 1'b0, 1'b1, 8);
        tick(7);
        chk_out("at_one", 1'b0, 1'b1, 1);
        bus.kick = 1'b1;
        tick();
        bus.kick = 1'b0;
        chk_out("last_kick", 1'b0, 1'b1, 8);

        // Disable in RUNNING at remaining==3.
        tick(5);
        chk_out("rem3", 1'b0, 1'b1, 3);
        bus.enable = 1'b0;
        tick();
        chk_out("dis_run", 1'b0, 1'b1, 0);
        tick(3);
        chk_out("dis_stay", 1'b0, 1'b1, 0);

        // Disable during FIRING: pulse completes, then IDLE.
        bus.enable = 1'b1;
        tick(8);
        chk_out("pre_fire", 1'b0, 1'b1, 1);
        tick();
        chk_out("fire1", 1'b1, 1'b1, 0);
        bus.enable = 1'b0;
        tick();
        chk_out("fire2_dis", 1'b1, 1'b1, 0);
        tick();
        chk_out("fire3_dis", 1'b1, 1'b1, 0);
        tick();
        chk_out("fire_exit_idle", 1'b0, 1'b1, 0);
        tick();
        chk_out("idle_after", 1'b0, 1'b1, 0);

        // clear_expired alone clears the flag.
        bus.clear_expired = 1'b1;
        tick();
        bus.clear_expired = 1'b0;
        chk_out("clear", 1'b0, 1'b0, 0);

        // Reset on the 2nd FIRING cycle.
        bus.enable = 1'b1;
        tick(8);
        chk_out("pre_fire_b", 1'b0, 1'b0, 1);
        tick();
        chk_out("fire1_b", 1'b1, 1'b1, 0);
        tick();
        chk_out("fire2_b", 1'b1, 1'b1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("mid_reset", 1'b0, 1'b0, 0);
        tick();
        chk_out("rearm", 1'b0, 1'b0, 8);

        // Clear coincident with FIRING entry loses; one cycle later it wins.
        tick(7);
        chk_out("pre_fire_c", 1'b0, 1'b0, 1);
        bus.clear_expired = 1'b1;
        tick();
        bus.clear_expired = 1'b0;
        chk_out("set_wins", 1'b1, 1'b1, 0);
        bus.clear_expired = 1'b1;
        tick();
        bus.clear_expired = 1'b0;
        chk_out("clear_in_fire", 1'b1, 1'b0, 0);
        tick();
        chk_out("fire3_c", 1'b1, 1'b0, 0);
        tick();
        chk_out("exit_run", 1'b0, 1'b0, 8);

        // Kick with enable low: enable wins.
        bus.enable = 1'b0;
        bus.kick   = 1'b1;
        tick();
        bus.kick = 1'b0;
        chk_out("dis_over_kick", 1'b0, 1'b0, 0);
        tick();
        chk_out("dis_over_kick2", 1'b0, 1'b0, 0);

        // Kicks during FIRING do not stretch or shorten the pulse.
        bus.enable = 1'b1;
        tick(8);
        chk_out("pre_fire_d", 1'b0, 1'b0, 1);
        tick();
        chk_out("fire1_d", 1'b1, 1'b1, 0);
        bus.kick = 1'b1;
        tick();
        chk_out("fire2_kick", 1'b1, 1'b1, 0);
        tick();
        chk_out("fire3_kick", 1'b1, 1'b1, 0);
        tick();
        bus.kick = 1'b0;
        chk_out("exit_kick", 1'b0, 1'b1, 8);
        tick();
        chk_out("run_after", 1'b0, 1'b1, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
